sram_like_arbiter: RTL
======================

SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of master channels (2..8; channel 0 = inst, 1 = data).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width (multiple of 8).
REQ-004 SHALL have parameter OST_DEPTH, default 4, max outstanding requests (power of 2, >=2).
REQ-005 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port m_req, input, N_CH, per-channel request.
REQ-008 SHALL have port m_wr, input, N_CH, per-channel write (1) / read (0).
REQ-009 SHALL have port m_wstrb, input, N_CH*DATA_W/8, per-channel byte strobes, channel i at slice i.
REQ-010 SHALL have port m_addr, input, N_CH*ADDR_W, per-channel address, channel i at slice i.
REQ-011 SHALL have port m_wdata, input, N_CH*DATA_W, per-channel write data, channel i at slice i.
REQ-012 SHALL have port m_addr_ok, output, N_CH, request accepted, one-hot or zero.
REQ-013 SHALL have port m_data_ok, output, N_CH, response returned, one-hot or zero.
REQ-014 SHALL have port m_rdata, output, DATA_W, read data broadcast to all channels.
REQ-015 SHALL have ports s_req/s_wr (out, 1), s_wstrb (out, DATA_W/8), s_addr (out, ADDR_W), s_wdata (out, DATA_W): downstream request.
REQ-016 SHALL have ports s_addr_ok, s_data_ok (in, 1), s_rdata (in, DATA_W): downstream handshake and response.
REQ-017 SHALL have port ost_count, output, log2(OST_DEPTH)+1, outstanding request count.
REQ-018 SHALL have port proto_err, output, 1, sticky flag for unexpected s_data_ok.

Function
REQ-019 Request handshake SHALL be s_req & s_addr_ok in one cycle; response SHALL be s_data_ok in one cycle.
REQ-020 Grant g SHALL be the first channel with m_req set, searching circularly from rr_ptr; combinational, zero-cycle request path.
REQ-021 s_req SHALL equal (any m_req, or lock valid) & (ost_count != OST_DEPTH); s_wr/s_wstrb/s_addr/s_wdata SHALL be channel g's fields.
REQ-022 If s_req=1 and s_addr_ok=0, grant SHALL be locked to g from the next cycle until its handshake; no re-arbitration while locked.
REQ-023 m_addr_ok[g] SHALL be 1 exactly in the handshake cycle; all other bits 0.
REQ-024 On handshake, rr_ptr SHALL become (g+1) mod N_CH and g SHALL be pushed into an in-order ID FIFO of depth OST_DEPTH.
REQ-025 On s_data_ok with FIFO non-empty: head ID h popped, m_data_ok[h]=1 same cycle, m_rdata = s_rdata combinationally.
REQ-026 Responses SHALL return strictly in request order across all channels.
REQ-027 Push and pop in the same cycle SHALL both occur; ost_count unchanged.
REQ-028 Full (ost_count == OST_DEPTH): s_req=0, no m_addr_ok, even if a pop occurs that cycle.
REQ-029 s_data_ok while empty: no m_data_ok, count stays 0, proto_err set to 1 and held until reset.
REQ-030 FIFO pointers SHALL wrap modulo OST_DEPTH; ost_count SHALL never exceed OST_DEPTH nor underflow.
REQ-031 m_rdata SHALL be s_rdata whenever s_data_ok=0 (don't-care to masters).
REQ-032 Masters SHALL hold request fields stable until m_addr_ok; block need not register them.

Reset
REQ-033 On reset: ost_count=0, FIFO pointers 0, rr_ptr=0, lock cleared, proto_err=0; outstanding requests discarded.
REQ-034 During reset cycle, m_addr_ok=0, m_data_ok=0; s_req follows REQ-021 with ost_count=0 state next cycle.
REQ-035 s_data_ok after reset for a pre-reset request SHALL set proto_err per REQ-029.

Verification
REQ-036 N_CH=2, both m_req=1, s_addr_ok=1 for 4 cycles -> grants 0,1,0,1; m_data_ok order 0,1,0,1 as s_data_ok returns.
REQ-037 m_req=01, s_addr_ok=0 for 3 cycles, m_req[1] rises cycle 2 -> grant stays ch0, m_addr_ok=01 on first s_addr_ok=1.
REQ-038 OST_DEPTH=4, 4 handshakes without s_data_ok -> ost_count=4, s_req=0; one s_data_ok -> ost_count=3, s_req=1 next cycle.
REQ-039 ost_count=2, handshake and s_data_ok same cycle -> ost_count stays 2, head channel gets m_data_ok.
REQ-040 s_data_ok=1 with ost_count=0 -> m_data_ok=0, proto_err=1 until reset; reset with ost_count=3 -> ost_count=0 next cycle.
REQ-041 Read ch1 addr 0x1c000010, s_rdata=0xDEADBEEF -> m_data_ok=10, m_rdata=0xDEADBEEF same cycle.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// Round-robin arbiter that merges N SRAM-like master channels onto one downstream port.
// Responses come back in request order through an ID FIFO of the granted channels.
module sram_like_arbiter #(
    parameter int N_CH      = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int OST_DEPTH = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [N_CH-1:0]                  m_req,
    input  logic [N_CH-1:0]                  m_wr,
    input  logic [N_CH*DATA_W/8-1:0]         m_wstrb,
    input  logic [N_CH*ADDR_W-1:0]           m_addr,
    input  logic [N_CH*DATA_W-1:0]           m_wdata,
    output logic [N_CH-1:0]                  m_addr_ok,
    output logic [N_CH-1:0]                  m_data_ok,
    output logic [DATA_W-1:0]                m_rdata,
    output logic                             s_req,
    output logic                             s_wr,
    output logic [DATA_W/8-1:0]              s_wstrb,
    output logic [ADDR_W-1:0]                s_addr,
    output logic [DATA_W-1:0]                s_wdata,
    input  logic                             s_addr_ok,
    input  logic                             s_data_ok,
    input  logic [DATA_W-1:0]                s_rdata,
    output logic [$clog2(OST_DEPTH):0]       ost_count,
    output logic                             proto_err
);

    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PTR_W  = $clog2(OST_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int STRB_W = DATA_W / 8;
    localparam logic [N_CH-1:0]  ONE_HOT0 = {{(N_CH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OST_DEPTH);

    logic [CH_W-1:0]  rr_ptr_r;
    logic             lock_valid_r;
    logic [CH_W-1:0]  lock_ch_r;
    logic [CH_W-1:0]  id_fifo_r [OST_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             proto_err_r;

    logic [CH_W-1:0]  search_s;
    logic [CH_W-1:0]  grant_s;
    logic [CH_W:0]    idx_s;
    logic             full_s;
    logic             empty_s;
    logic             hs_s;
    logic             pop_s;

    // Circular first-set search from rr_ptr; scanning backwards lets the nearest requester win.
    always_comb begin
        search_s = rr_ptr_r;
        idx_s    = {(CH_W+1){1'b0}};
        for (int k = N_CH - 1; k >= 0; k--) begin
            idx_s = {1'b0, rr_ptr_r} + (CH_W+1)'(k);
            idx_s = (idx_s >= (CH_W+1)'(N_CH)) ? (idx_s - (CH_W+1)'(N_CH)) : idx_s;
            search_s = m_req[idx_s[CH_W-1:0]] ? idx_s[CH_W-1:0] : search_s;
        end
        grant_s = lock_valid_r ? lock_ch_r : search_s;
    end

    // Downstream request mux, handshake decode and per-channel strobes.
    always_comb begin
        full_s    = (count_r == CNT_FULL);
        empty_s   = (count_r == {CNT_W{1'b0}});
        s_req     = ((|m_req) | lock_valid_r) & ~full_s;
        s_wr      = m_wr[grant_s];
        s_wstrb   = m_wstrb[grant_s*STRB_W +: STRB_W];
        s_addr    = m_addr[grant_s*ADDR_W +: ADDR_W];
        s_wdata   = m_wdata[grant_s*DATA_W +: DATA_W];
        hs_s      = s_req & s_addr_ok & ~reset;
        pop_s     = s_data_ok & ~empty_s & ~reset;
        m_addr_ok = hs_s  ? (ONE_HOT0 << grant_s) : {N_CH{1'b0}};
        m_data_ok = pop_s ? (ONE_HOT0 << id_fifo_r[rd_ptr_r]) : {N_CH{1'b0}};
        m_rdata   = s_rdata;
        ost_count = count_r;
        proto_err = proto_err_r;
    end

    // ID FIFO storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clock) begin
        if (hs_s) begin
            id_fifo_r[wr_ptr_r] <= grant_s;
        end else begin
            id_fifo_r[wr_ptr_r] <= id_fifo_r[wr_ptr_r];
        end
    end

    // Arbitration state, FIFO pointers, outstanding count and sticky protocol error.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_r     <= {CH_W{1'b0}};
            lock_valid_r <= 1'b0;
            lock_ch_r    <= {CH_W{1'b0}};
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            count_r      <= {CNT_W{1'b0}};
            proto_err_r  <= 1'b0;
        end else begin
            if (hs_s) begin
                wr_ptr_r     <= wr_ptr_r + PTR_W'(1);
                rr_ptr_r     <= (grant_s == CH_W'(N_CH - 1)) ? {CH_W{1'b0}} : grant_s + CH_W'(1);
                lock_valid_r <= 1'b0;
            end else if (s_req) begin
                // Downstream stalled: pin the grant so the request fields stay stable.
                lock_valid_r <= 1'b1;
                lock_ch_r    <= grant_s;
            end else begin
                lock_valid_r <= lock_valid_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({hs_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            if (s_data_ok && empty_s) begin
                proto_err_r <= 1'b1;
            end else begin
                proto_err_r <= proto_err_r;
            end
        end
    end

endmodule
